// File: rtl/mux_sweep_capture_pkg.sv
// mux_sweep_capture_pkg: shared state encodings and sweep sizing
package mux_sweep_capture_pkg;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } state_t;
    localparam int NUM_VECTORS = 32;
    localparam int IDX_W = 5;
endpackage

// File: rtl/mux_sweep_capture_settle.sv
// settle_timer: counts hold cycles per vector and ticks on the last one
module settle_timer #(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic tick
);
    logic [CNT_W-1:0] count;
    assign tick = count == CNT_W'(SETTLE_CYCLES - 1);
    // free-running hold counter, wraps on tick, held at zero while cleared
    always_ff @(posedge clk) begin
        if (reset || clear) count <= '0;
        else if (en) count <= tick ? '0 : count + 1'b1;
    end
endmodule

// File: rtl/mux_sweep_capture.sv
// mux_sweep_capture: sweeps all {Y,X} vectors, captures Z and checks against a golden word
module mux_sweep_capture
    import mux_sweep_capture_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] expected,
    input  logic        Z_in,
    output logic [1:0]  Y_out,
    output logic [2:0]  X_out,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        pass,
    output logic [5:0]  mismatch_count
);
    state_t state;
    logic [IDX_W-1:0] idx;
    logic [31:0] exp_q;
    logic [31:0] res_next;
    logic tick;
    logic last;
    assign Y_out = idx[4:3];
    assign X_out = idx[2:0];
    assign last = idx == IDX_W'(NUM_VECTORS - 1);
    settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES), .CNT_W(CNT_W)) u_timer (
        .clk(clk),
        .reset(reset),
        .clear(state != ST_SWEEP),
        .en(state == ST_SWEEP),
        .tick(tick)
    );
    // result with the current sample merged in, so pass sees the final bit
    always_comb begin
        res_next = result;
        res_next[idx] = Z_in;
    end
    // sweep FSM: accept start, step vectors on each settle tick, finish at index 31
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            idx <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            pass <= 1'b0;
            result <= '0;
            mismatch_count <= '0;
            exp_q <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: if (start) begin
                    exp_q <= expected;
                    result <= '0;
                    mismatch_count <= '0;
                    pass <= 1'b0;
                    done <= 1'b0;
                    idx <= '0;
                    busy <= 1'b1;
                    state <= ST_SWEEP;
                end
                ST_SWEEP: if (tick) begin
                    result <= res_next;
                    mismatch_count <= mismatch_count + 6'(Z_in != exp_q[idx]);
                    idx <= idx + 1'b1;
                    if (last) begin
                        state <= ST_DONE;
                        busy <= 1'b0;
                        done <= 1'b1;
                        pass <= res_next == exp_q;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mux_sweep_capture.sv
// tb_mux_sweep_capture: table-driven and randomized sweeps checked against a truth-table model
module tb_mux_sweep_capture;
    logic clk = 0;
    logic reset = 1;
    logic start = 0, start_b = 0;
    logic [31:0] expected = 0, expected_b = 0;
    logic [31:0] zsrc = 0, zsrc_b = 0;
    logic z_in, z_in_b;
    logic [1:0] y, y_b;
    logic [2:0] x, x_b;
    logic busy, done, pass, busy_b, done_b, pass_b;
    logic [31:0] result, result_b;
    logic [5:0] mm, mm_b;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    assign z_in = zsrc[{y, x}];
    assign z_in_b = zsrc_b[{y_b, x_b}];

    mux_sweep_capture #(.SETTLE_CYCLES(2), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .start(start), .expected(expected), .Z_in(z_in),
        .Y_out(y), .X_out(x), .busy(busy), .done(done), .result(result),
        .pass(pass), .mismatch_count(mm)
    );

    mux_sweep_capture #(.SETTLE_CYCLES(1), .CNT_W(4)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .expected(expected_b), .Z_in(z_in_b),
        .Y_out(y_b), .X_out(x_b), .busy(busy_b), .done(done_b), .result(result_b),
        .pass(pass_b), .mismatch_count(mm_b)
    );

    typedef struct {
        logic [31:0] e;
        logic [31:0] z;
        logic [31:0] res;
        logic [5:0]  mm;
        logic        ps;
        bit          poke;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    task automatic do_sweep(input string name, input vec_t v);
        int order_bad = 0;
        @(negedge clk);
        expected = v.e;
        zsrc = v.z;
        start = 1;
        @(negedge clk);
        start = 0;
        for (int j = 0; j < 64; j++) begin
            if ({y, x} != 5'(j / 2) || !busy || done) order_bad++;
            start = v.poke && (j == 10 || j == 40 || j == 63);
            if (v.poke && j == 30) expected = ~v.e;
            @(negedge clk);
        end
        start = 0;
        check({name, "_order"}, order_bad, 0);
        check({name, "_done"}, {busy, done}, 2'b01);
        check({name, "_idx0"}, {y, x}, 0);
        check({name, "_result"}, result, v.res);
        check({name, "_mm"}, mm, v.mm);
        check({name, "_pass"}, pass, v.ps);
        repeat (3) @(negedge clk);
        check({name, "_hold"}, {busy, done, pass, mm}, {2'b01, v.ps, v.mm});
        check({name, "_hold_res"}, result, v.res);
    endtask

    initial begin
        int order_b = 0;
        tbl[0] = '{32'hA5A5_3C3C, 32'hA5A5_3C3C, 32'hA5A5_3C3C, 6'd0, 1'b1, 1'b0};
        tbl[1] = '{32'hA5A5_3C3C, 32'h0000_0000, 32'h0000_0000, 6'd16, 1'b0, 1'b0};
        tbl[2] = '{32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 6'd0, 1'b1, 1'b1};
        for (int i = 3; i < 8; i++) begin
            tbl[i].e = $urandom;
            tbl[i].z = i == 3 ? tbl[i].e : i == 4 ? tbl[i].e ^ (32'd1 << $urandom_range(31)) : $urandom;
            tbl[i].res = tbl[i].z;
            tbl[i].mm = 6'($countones(tbl[i].z ^ tbl[i].e));
            tbl[i].ps = tbl[i].z == tbl[i].e;
            tbl[i].poke = i == 7;
        end

        repeat (2) @(negedge clk);
        check("rst_ctl", {busy, done, pass, y, x}, 0);
        check("rst_res", result, 0);
        check("rst_mm", mm, 0);
        check("rst_b", {busy_b, done_b, result_b, mm_b}, 0);
        reset = 0;

        for (int i = 0; i < 8; i++) do_sweep($sformatf("vec%0d", i), tbl[i]);

        @(negedge clk);
        expected = 32'hA5A5_3C3C;
        zsrc = 32'hA5A5_3C3C;
        start = 1;
        @(negedge clk);
        start = 0;
        repeat (20) @(negedge clk);
        check("pre_reset_vec", {y, x}, 10);
        reset = 1;
        @(negedge clk);
        reset = 0;
        check("mid_rst_ctl", {busy, done, pass, y, x}, 0);
        check("mid_rst_res", result, 0);
        check("mid_rst_mm", mm, 0);
        @(negedge clk);
        check("mid_rst_idle", {busy, y, x}, 0);
        do_sweep("after_rst", tbl[0]);

        @(negedge clk);
        expected_b = 32'hFFFF_0000;
        zsrc_b = 32'h0000_FFFF;
        start_b = 1;
        @(negedge clk);
        start_b = 0;
        for (int j = 0; j < 32; j++) begin
            if ({y_b, x_b} != 5'(j) || !busy_b || done_b) order_b++;
            @(negedge clk);
        end
        check("s1_order", order_b, 0);
        check("s1_done", {busy_b, done_b}, 2'b01);
        check("s1_result", result_b, 32'h0000_FFFF);
        check("s1_mm", mm_b, 32);
        check("s1_pass", pass_b, 0);
        start_b = 1;
        @(negedge clk);
        start_b = 0;
        check("s1_restart", {busy_b, done_b, pass_b, mm_b}, 9'b1_0000_0000 << 0 | {2'b10, 7'd0});
        check("s1_restart_res", result_b, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
